pll_supervisor: RTL and testbench
=================================

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Generic RST_CYCLES, default 16: width of each PLL reset pulse in clk cycles (>=1).
REQ-002 Generic LOCK_TIMEOUT, default 50000: maximum clk cycles in WAIT_LOCK before a retry (>=1).
REQ-003 Generic STABLE_CYCLES, default 1000: consecutive synchronized-lock cycles required before ok asserts (>=1).
REQ-004 Generic MAX_RETRY, default 3: retries allowed after the initial pulse before FAIL (0..15).
REQ-005 clk  in  1  PLL reference clock (50 MHz); the block's only clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 restart  in  1  synchronous single-cycle request to restart the lock sequence.
REQ-008 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-009 pll_rst  out  1  reset to the PLL, active-high.
REQ-010 ok  out  1  PLL output clock is stable and usable.
REQ-011 fail  out  1  lock not achieved within MAX_RETRY retries.
REQ-012 retries  out  4  retries consumed in the current attempt sequence.
REQ-013 lost  out  8  count of lock losses from RUN, saturating at 255.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer to form locked_s; no other logic SHALL use pll_locked.
REQ-015 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABLE_WAIT, RUN, FAIL; all outputs are registered Moore outputs.
REQ-016 RESET_PLL: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK with cycle counter cleared.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 -> STABLE_WAIT (counter cleared); counter reaches LOCK_TIMEOUT-1 with locked_s=0 -> RESET_PLL with retries+1 if retries<MAX_RETRY, else FAIL.
REQ-018 STABLE_WAIT: locked_s=0 -> WAIT_LOCK with timeout counter cleared; STABLE_CYCLES consecutive cycles of locked_s=1 -> RUN.
REQ-019 Latency: if edge 1 is the first to sample pll_locked=1 and lock holds, ok SHALL be high after edge 3+STABLE_CYCLES.
REQ-020 RUN: ok=1, pll_rst=0; locked_s=0 -> RESET_PLL, retries<=0, lost+1 (saturating); ok low after the 3rd edge sampling pll_locked=0.
REQ-021 FAIL: pll_rst=1 and fail=1 held indefinitely; exits only on rst or restart.
REQ-022 restart=1 in any state -> RESET_PLL next cycle, counter cleared, retries<=0, fail<=0; lost unchanged; restart takes priority over all other transitions.
REQ-023 Counter SHALL be sized for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) and never wrap within a state.

Reset
REQ-024 While rst=1: state=RESET_PLL, counter=0, synchronizer=0, pll_rst=1, ok=0, fail=0, retries=0, lost=0, applied immediately without clk.
REQ-025 After rst deasserts, RESET_PLL SHALL run its full RST_CYCLES before pll_rst falls.

Structure
REQ-026 Package pll_supervisor_pkg SHALL hold the state enumeration type and the counter-width function.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_reg (2 stages, reset value 0).

Verification (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2)
REQ-028 Normal lock: release rst, raise pll_locked 6 cycles after pll_rst falls -> pll_rst high exactly 4 cycles, ok high after edge 11 counted from first high sample, fail=0, retries=0.
REQ-029 Never lock: pll_locked=0 -> three 4-cycle pll_rst pulses 20 cycles apart, retries 0->1->2, then fail=1, pll_rst=1 held, ok=0.
REQ-030 Glitch: pll_locked high 5 cycles, low 1 cycle, then high -> ok never asserts early; ok rises 11 edges after the re-rise sample.
REQ-031 Lock loss in RUN: drop pll_locked -> ok low after 3rd edge, 4-cycle pll_rst pulse, lost=1, retries=0; relock -> ok returns.
REQ-032 restart in FAIL -> fail=0, retries=0, 4-cycle pll_rst pulse, lost unchanged.
REQ-033 Async rst asserted mid-WAIT_LOCK between clk edges -> pll_rst=1, ok=0, counters 0 before the next edge.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg
//   Shared types and helpers for the PLL supervisor.
//   state_t   : supervisor FSM state encoding
//   cnt_width : width of the shared cycle counter, wide enough for the
//               largest terminal count of all timed states.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        RESET_PLL   = 3'd0,
        WAIT_LOCK   = 3'd1,
        STABLE_WAIT = 3'd2,
        RUN         = 3'd3,
        FAIL        = 3'd4
    } state_t;

    // The counter only ever has to hold (max - 1), so $clog2(max) bits suffice.
    function automatic int cnt_width(input int unsigned a,
                                     input int unsigned b,
                                     input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_reg.sv
// sync_reg
//   Multi-flop synchronizer for a single asynchronous level input.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronized output, STAGES clk edges behind d
module sync_reg #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor
//   Sequences PLL reset, waits for lock with timeout and limited retries,
//   qualifies lock over a stability window and watches for lock loss.
//   clk        : reference clock, the block's only clock
//   rst        : asynchronous active-high reset
//   restart    : single-cycle request to restart the lock sequence
//   pll_locked : PLL lock indicator, asynchronous to clk
//   pll_rst    : reset to the PLL (active-high)
//   ok         : PLL output clock stable and usable
//   fail       : lock not achieved within the allowed retries
//   retries    : retries consumed in the current attempt sequence
//   lost       : count of lock losses while running, saturating at 255
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   RESET_PLL   | pll_rst held high for RST_CYCLES cycles
//   WAIT_LOCK   | pll_rst low, waiting up to LOCK_TIMEOUT cycles for lock
//   STABLE_WAIT | lock seen, requiring STABLE_CYCLES consecutive lock cycles
//   RUN         | lock qualified, ok high, watching for lock loss
//   FAIL        | retries exhausted, PLL held in reset until restart/rst
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned MAX_RETRY     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       ok,
    output logic       fail,
    output logic [3:0] retries,
    output logic [7:0] lost
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    retries_nxt;
    logic [7:0]    lost_nxt;
    logic          pll_rst_nxt, ok_nxt, fail_nxt;
    logic          locked_s;

    sync_reg #(.STAGES(2)) u_sync_locked (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // State register, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RESET_PLL;
            cnt     <= '0;
            retries <= '0;
            lost    <= '0;
            pll_rst <= 1'b1;
            ok      <= 1'b0;
            fail    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            retries <= retries_nxt;
            lost    <= lost_nxt;
            pll_rst <= pll_rst_nxt;
            ok      <= ok_nxt;
            fail    <= fail_nxt;
        end
    end

    // Next-state logic; restart overrides every other transition.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        retries_nxt = retries;
        lost_nxt    = lost;
        if (restart) begin
            state_nxt   = RESET_PLL;
            cnt_nxt     = '0;
            retries_nxt = '0;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE_WAIT;
                        cnt_nxt   = '0;
                    end else if (cnt == LOCK_LAST) begin
                        cnt_nxt = '0;
                        if (retries < RETRY_MAX) begin
                            state_nxt   = RESET_PLL;
                            retries_nxt = retries + 4'd1;
                        end else begin
                            state_nxt = FAIL;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                STABLE_WAIT: begin
                    if (!locked_s) begin
                        state_nxt = WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_nxt   = RESET_PLL;
                        cnt_nxt     = '0;
                        retries_nxt = '0;
                        if (lost != 8'hFF) lost_nxt = lost + 8'd1;
                    end
                end
                FAIL: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = RESET_PLL;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered outputs
    // line up with the state register on the same edge.
    always_comb begin
        pll_rst_nxt = 1'b0;
        ok_nxt      = 1'b0;
        fail_nxt    = 1'b0;
        case (state_nxt)
            RESET_PLL: pll_rst_nxt = 1'b1;
            RUN:       ok_nxt      = 1'b1;
            FAIL: begin
                pll_rst_nxt = 1'b1;
                fail_nxt    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pll_supervisor.sv
module tb_pll_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       restart;
    logic       pll_locked;
    logic       pll_rst;
    logic       ok;
    logic       fail;
    logic [3:0] retries;
    logic [7:0] lost;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        int unsigned exp;
    } exp_t;

    exp_t sb[$];

    pll_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .ok         (ok),
        .fail       (fail),
        .retries    (retries),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input int unsigned v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input int unsigned obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts edges until pll_rst reaches level; bounded so a stuck DUT
    // shows up as a wrong count rather than a hang.
    task automatic wait_rst(input logic level, output int n);
        n = 0;
        while (pll_rst !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int   n;
        logic ok_seen;

        rst        = 1'b1;
        restart    = 1'b0;
        pll_locked = 1'b0;
        tick(3);

        // Reset state
        push("rst_pll_rst", 1); check(pll_rst);
        push("rst_ok", 0);      check(ok);
        push("rst_fail", 0);    check(fail);
        push("rst_retries", 0); check(retries);
        push("rst_lost", 0);    check(lost);

        // Normal lock
        rst = 1'b0;
        push("init_pulse_len", 4);
        wait_rst(1'b0, n); check(n);
        tick(6);
        pll_locked = 1'b1;
        push("lock_ok_early", 0);
        tick(10); check(ok);
        push("lock_ok", 1);
        tick(1); check(ok);
        push("lock_fail", 0);    check(fail);
        push("lock_retries", 0); check(retries);

        // Lock loss in RUN, then relock
        pll_locked = 1'b0;
        push("loss_ok_edge2", 1);
        tick(2); check(ok);
        push("loss_ok_edge3", 0);
        tick(1); check(ok);
        push("loss_pll_rst", 1); check(pll_rst);
        push("loss_lost", 1);    check(lost);
        push("loss_retries", 0); check(retries);
        push("loss_pulse_len", 4);
        wait_rst(1'b0, n); check(n);
        pll_locked = 1'b1;
        push("relock_ok_early", 0);
        tick(10); check(ok);
        push("relock_ok", 1);
        tick(1); check(ok);

        // Restart from RUN, then a lock glitch during qualification
        pll_locked = 1'b0;
        restart    = 1'b1;
        tick(1);
        restart = 1'b0;
        push("rs_run_pll_rst", 1); check(pll_rst);
        push("rs_run_lost", 1);    check(lost);
        push("rs_run_pulse_len", 4);
        wait_rst(1'b0, n); check(n);
        ok_seen    = 1'b0;
        pll_locked = 1'b1;
        repeat (5) begin tick(1); ok_seen |= ok; end
        pll_locked = 1'b0;
        tick(1); ok_seen |= ok;
        pll_locked = 1'b1;
        repeat (10) begin tick(1); ok_seen |= ok; end
        push("glitch_ok_early", 0); check(ok_seen);
        push("glitch_ok", 1);
        tick(1); check(ok);

        // Never lock: three pulses, then FAIL
        pll_locked = 1'b0;
        restart    = 1'b1;
        tick(1);
        restart = 1'b0;
        push("nl_lost", 1); check(lost);
        for (int p = 0; p < 3; p++) begin
            push($sformatf("nl_pulse%0d_len", p), 4);
            wait_rst(1'b0, n); check(n);
            push($sformatf("nl_retries%0d", p), p); check(retries);
            push($sformatf("nl_fail%0d", p), 0);    check(fail);
            push($sformatf("nl_gap%0d_len", p), 20);
            wait_rst(1'b1, n); check(n);
        end
        push("nl_fail", 1);    check(fail);
        push("nl_ok", 0);      check(ok);
        push("nl_retries", 2); check(retries);
        tick(30);
        push("nl_hold_pll_rst", 1); check(pll_rst);
        push("nl_hold_fail", 1);    check(fail);

        // Restart from FAIL
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        push("rs_fail_fail", 0);    check(fail);
        push("rs_fail_retries", 0); check(retries);
        push("rs_fail_pll_rst", 1); check(pll_rst);
        push("rs_fail_lost", 1);    check(lost);
        push("rs_fail_pulse_len", 4);
        wait_rst(1'b0, n); check(n);

        // Asynchronous reset between edges during WAIT_LOCK
        tick(3);
        push("async_pre_pll_rst", 0); check(pll_rst);
        #2 rst = 1'b1;
        #1;
        push("async_pll_rst", 1); check(pll_rst);
        push("async_ok", 0);      check(ok);
        push("async_fail", 0);    check(fail);
        push("async_retries", 0); check(retries);
        push("async_lost", 0);    check(lost);
        tick(1);
        rst = 1'b0;
        push("async_post_pulse_len", 4);
        wait_rst(1'b0, n); check(n);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
